seg_display_drv: RTL

Memory-mapped output driver for the board's 8-digit, common-anode seven-segment display. It is the write-side counterpart of the switch input peripheral: the CPU bus stores a 32-bit word into a display register, and the block time-multiplexes the eight hex nibbles onto the shared segment lines with a programmable refresh rate. It sits on the SoC peripheral bus next to the switch and LED peripherals and drives the board pins directly.

---
 rtl/seg_display_drv.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_display_drv.sv
// -----------------------------------------------------------------------------
// seg_display_drv
//
// Write-side display peripheral for an 8-digit, common-anode seven-segment
// display. The bus writes a 32-bit word into the display register. Each hex
// nibble is then shown on its own digit. The eight digits share the segment
// lines and are time-multiplexed, with each digit lit for SCAN_DIV cycles.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit stays lit (>= 1)
//
// Ports:
//   clk           system clock (single domain)
//   rst           synchronous, active-high reset
//   we            write strobe, sampled on the rising edge of clk
//   wdata[31:0]   word to display; nibble i drives digit i (digit 0 rightmost)
//   rd_data[31:0] current display register, combinational readback
//   dig_en[7:0]   digit anode enables, active-low, registered
//   seg[7:0]      segments {dp,g,f,e,d,c,b,a}, active-low, registered
//
// Handshake: none. A write with we=1 is always accepted on that edge. There
// is no stall and no acknowledge.
//
// Build option:
//   SEG_BLANK_EN  when defined, leading-zero blanking is enabled. Digit i > 0
//                 is dark during its slot when nibbles i..7 are all zero.
//                 Digit 0 is never blanked, and slot timing is unchanged.
// -----------------------------------------------------------------------------
module seg_display_drv #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [31:0]   r_data;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_dig_en;
  logic [7:0]    r_seg;

  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [7:0]    w_hex;
  logic          w_blank;

  // With SCAN_DIV = 1, CNT_LAST is 0, so the digit advances every cycle.
  assign w_wrap = (r_cnt == CNT_LAST);
  assign w_nib  = r_data[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_hex = 8'hFF;
    case (w_nib)
      4'h0: w_hex = 8'hC0;
      4'h1: w_hex = 8'hF9;
      4'h2: w_hex = 8'hA4;
      4'h3: w_hex = 8'hB0;
      4'h4: w_hex = 8'h99;
      4'h5: w_hex = 8'h92;
      4'h6: w_hex = 8'h82;
      4'h7: w_hex = 8'hF8;
      4'h8: w_hex = 8'h80;
      4'h9: w_hex = 8'h90;
      4'hA: w_hex = 8'h88;
      4'hB: w_hex = 8'h83;
      4'hC: w_hex = 8'hC6;
      4'hD: w_hex = 8'hA1;
      4'hE: w_hex = 8'h86;
      4'hF: w_hex = 8'h8E;
      default: w_hex = 8'hFF;
    endcase
  end

`ifdef SEG_BLANK_EN
  // w_upper_zero[i] is set when nibbles i..7 are all zero. It is built
  // from the top nibble downward.
  logic [7:0] w_upper_zero;

  always_comb begin
    w_upper_zero    = 8'h00;
    w_upper_zero[7] = (r_data[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] & (r_data[4*i +: 4] == 4'h0);
    end
  end

  assign w_blank = (r_idx != 3'd0) && w_upper_zero[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= 32'h0;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_dig_en <= 8'hFF;
      r_seg    <= 8'hFF;
    end else begin
      if (we) begin
        r_data <= wdata;
      end

      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Output stage reflects the index/data as they stood before this edge.
      // A new idx or data therefore shows up one edge later.
      if (w_blank) begin
        r_dig_en <= 8'hFF;
        r_seg    <= 8'hFF;
      end else begin
        r_dig_en <= ~(8'b1 << r_idx);
        r_seg    <= w_hex;
      end
    end
  end

  assign rd_data = r_data;
  assign dig_en  = r_dig_en;
  assign seg     = r_seg;

endmodule
